// File: rtl/roll_over_counter_pkg.sv
// Shared types and constants for the roll-over prescaler.
package roll_over_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } t_roll_state;

   localparam int MIN_LIMIT   = 1;
   localparam int ROLL_N_BITS = 16;

endpackage

// File: rtl/roll_over_counter_if.sv
// Limit-load handshake between a host (master) and the roll-over counter (slave).
interface roll_over_counter_if
   import roll_over_pkg::*;
#(
   parameter int N_BITS = ROLL_N_BITS
);

   logic [N_BITS-1:0] i_limit;
   logic              i_load;
   logic              o_load_ready;

   modport master (output i_limit, output i_load, input  o_load_ready);
   modport slave  (input  i_limit, input  i_load, output o_load_ready);

endinterface

// File: rtl/roll_over_limit_reg.sv
// Shadow/active limit registers: accepts one clamped limit and moves it to the
// active register when the counter raises i_apply (period boundary or idle).
module roll_over_limit_reg
   import roll_over_pkg::*;
#(
   parameter int N_BITS        = ROLL_N_BITS,
   parameter int DEFAULT_LIMIT = 24999
) (
   input  logic                i_clk,
   input  logic                i_reset,
   roll_over_counter_if.slave  load_if,
   input  logic                i_apply,
   output logic [N_BITS-1:0]   o_limit
);

   localparam logic [N_BITS-1:0] MIN_L       = N_BITS'(MIN_LIMIT);
   localparam logic [N_BITS-1:0] DEF_L       = N_BITS'(DEFAULT_LIMIT);
   localparam logic [N_BITS-1:0] RESET_LIMIT = (DEF_L < MIN_L) ? MIN_L : DEF_L;

   logic [N_BITS-1:0] shadow_q;
   logic [N_BITS-1:0] limit_q;
   logic              pending_q;
   logic [N_BITS-1:0] limit_d;

   // A zero limit would hold the pulse high forever; raise it to the minimum.
   assign limit_d = (load_if.i_limit < MIN_L) ? MIN_L : load_if.i_limit;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shadow_q  <= '0;
         limit_q   <= RESET_LIMIT;
         pending_q <= 1'b0;
      end else if (pending_q && i_apply) begin
         limit_q   <= shadow_q;
         pending_q <= 1'b0;
      end else if (load_if.i_load && !pending_q) begin
         shadow_q  <= limit_d;
         pending_q <= 1'b1;
      end
   end

   assign load_if.o_load_ready = ~pending_q;
   assign o_limit              = limit_q;

endmodule

// File: rtl/roll_over_counter.sv
// Prescaler: counts cycles in RUN and pulses o_roll_over when count hits the
// active limit. Optional rollover tally output enabled by ROLL_OVER_TALLY_EN.
module roll_over_counter
   import roll_over_pkg::*;
#(
   parameter int N_BITS        = ROLL_N_BITS,
   parameter int DEFAULT_LIMIT = 24999
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   roll_over_counter_if.slave  load_if,
   output logic                o_roll_over,
   output logic [N_BITS-1:0]   o_count
`ifdef ROLL_OVER_TALLY_EN
   ,
   output logic [7:0]          o_tally
`endif
);

   t_roll_state       state_q;
   logic [N_BITS-1:0] count_q;
   logic [N_BITS-1:0] count_d;
   logic              roll_q;
   logic              roll_d;
   logic              apply;
   logic [N_BITS-1:0] limit;

   assign count_d = count_q + 1'b1;
   assign roll_d  = (state_q == RUN) && i_enable && (count_q >= limit);
   // Idle has no period in flight, so a pending limit can go live at once.
   assign apply   = (state_q == IDLE) || roll_d;

   roll_over_limit_reg #(
      .N_BITS        (N_BITS),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
   ) u_limit_reg (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .load_if (load_if),
      .i_apply (apply),
      .o_limit (limit)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         count_q <= '0;
         roll_q  <= 1'b0;
      end else begin
         roll_q <= roll_d;
         case (state_q)
            IDLE: begin
               count_q <= '0;
               if (i_enable) state_q <= RUN;
            end
            RUN: begin
               if (!i_enable) begin
                  state_q <= IDLE;
                  count_q <= '0;
               end else if (roll_d) begin
                  count_q <= '0;
               end else begin
                  count_q <= count_d;
               end
            end
         endcase
      end
   end

`ifdef ROLL_OVER_TALLY_EN
   logic [7:0] tally_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)    tally_q <= '0;
      else if (roll_d) tally_q <= tally_q + 8'd1;
   end

   assign o_tally = tally_q;
`endif

   assign o_roll_over = roll_q;
   assign o_count     = count_q;

endmodule
